// File: rtl/stebus_pkg.sv
// Shared encodings for the STEbus slave front end: command modifiers, FSM states, bus widths.
package stebus_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 12;

    localparam logic [1:0] CM_IO   = 2'b01;
    localparam logic       CM_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Decoded command modifier: only I/O cycles are ever candidates for a match.
    typedef struct packed {
        logic io;
        logic read;
    } bus_cmd_t;

    function automatic bus_cmd_t decode_cm(input logic [2:0] cm);
        bus_cmd_t cmd;
        cmd.io   = (cm[2:1] == CM_IO);
        cmd.read = (cm[0] == CM_READ);
        return cmd;
    endfunction

endpackage

// File: rtl/stebus_sync.sv
// Flop-chain synchroniser for an asynchronous active-low strobe; resets to the inactive level.
module stebus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/stebus_decode.sv
// STEbus slave front end: synchronises strobes, decodes the I/O window, issues one-cycle
// register strobes and drives the active-low select and read data for the DATACK stage.
module stebus_decode
    import stebus_pkg::*;
#(
    parameter logic [11:0]  BASE_ADDR   = 12'h0C0,
    parameter int unsigned  REG_BITS    = 3,
    parameter int unsigned  SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adrstb_n,
    input  logic                datstb_n,
    input  logic [2:0]          cm,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_oe,
    output logic                cs,
    output logic [REG_BITS-1:0] reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic                reg_wr,
    output logic                reg_rd,
    input  logic [DATA_W-1:0]   reg_rdata
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    logic       adrstb_s;
    logic       datstb_s;
    logic       armed;
    logic       settled;
    logic [CNT_W-1:0] fill_cnt;
    bus_cmd_t   cmd;
    logic       hit;

    state_t                state, state_nx;
    logic                  cs_nx;
    logic                  data_oe_nx;
    logic [DATA_W-1:0]     data_out_nx;
    logic                  reg_wr_nx;
    logic                  reg_rd_nx;
    logic [REG_BITS-1:0]   reg_addr_nx;
    logic [DATA_W-1:0]     reg_wdata_nx;

    stebus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adr (
        .clk (clk),
        .rst (rst),
        .d   (adrstb_n),
        .q   (adrstb_s)
    );

    stebus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk (clk),
        .rst (rst),
        .d   (datstb_n),
        .q   (datstb_s)
    );

    assign cmd = decode_cm(cm);
    assign hit = cmd.io && (addr[ADDR_W-1:REG_BITS] == BASE_ADDR[ADDR_W-1:REG_BITS]);

    // The synchroniser output is its reset value until refilled, so only a genuinely
    // sampled high DATSTB* may arm the decoder after reset.
    assign settled = (fill_cnt == CNT_W'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (!settled) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
            if (settled && datstb_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cs        <= 1'b1;
            data_oe   <= 1'b0;
            data_out  <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_nx;
            cs        <= cs_nx;
            data_oe   <= data_oe_nx;
            data_out  <= data_out_nx;
            reg_wr    <= reg_wr_nx;
            reg_rd    <= reg_rd_nx;
            reg_addr  <= reg_addr_nx;
            reg_wdata <= reg_wdata_nx;
        end
    end

    // Next-state and next-output decode; reg_rd still marks a read while in STROBE.
    always_comb begin
        state_nx     = state;
        cs_nx        = cs;
        data_oe_nx   = data_oe;
        data_out_nx  = data_out;
        reg_wr_nx    = reg_wr;
        reg_rd_nx    = reg_rd;
        reg_addr_nx  = reg_addr;
        reg_wdata_nx = reg_wdata;

        case (state)
            IDLE: begin
                if (armed && !adrstb_s && !datstb_s && hit) begin
                    reg_addr_nx = addr[REG_BITS-1:0];
                    if (cmd.read) begin
                        reg_rd_nx = 1'b1;
                    end else begin
                        reg_wdata_nx = data_in;
                        reg_wr_nx    = 1'b1;
                    end
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                reg_wr_nx = 1'b0;
                reg_rd_nx = 1'b0;
                cs_nx     = 1'b0;
                if (reg_rd) begin
                    data_out_nx = reg_rdata;
                    data_oe_nx  = 1'b1;
                end
                state_nx = HOLD;
            end
            HOLD: begin
                if (datstb_s) begin
                    cs_nx      = 1'b1;
                    data_oe_nx = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stebus_decode.sv
// Self-checking bench for stebus_decode: scenario tasks plus a scoreboard of expected strobes.
module tb_stebus_decode;

    localparam int unsigned SYNC = 2;
    localparam logic [11:0] BASE = 12'h0C0;

    logic        clk = 1'b0;
    logic        rst;
    logic        adrstb_n;
    logic        datstb_n;
    logic [2:0]  cm;
    logic [11:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        cs;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;

    always #5 clk = ~clk;

    stebus_decode #(
        .BASE_ADDR   (BASE),
        .REG_BITS    (3),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adrstb_n  (adrstb_n),
        .datstb_n  (datstb_n),
        .cm        (cm),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .cs        (cs),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata)
    );

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    bit   pend      = 1'b0;
    bit   pend_rd   = 1'b0;
    logic [7:0] pend_data = 8'h00;

    function automatic bit model_hit(input logic [11:0] a, input logic [2:0] c);
        return (c[2:1] == 2'b01) && (a[11:3] == BASE[11:3]);
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expected access, and the
    // following cycle must show cs low (and read data on the bus for reads).
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pend) begin
                checks++;
                if (cs !== 1'b0 || data_oe !== pend_rd || (pend_rd && data_out !== pend_data)) begin
                    errors++;
                    $display("FAIL strobe_follow: cs=%b data_oe=%b data_out=%h, required cs=0 data_oe=%b data_out=%h",
                             cs, data_oe, data_out, pend_rd, pend_data);
                end
                pend = 1'b0;
            end
            if (reg_wr === 1'b1 || reg_rd === 1'b1) begin
                if (reg_wr === 1'b1) wr_pulses++;
                if (reg_rd === 1'b1) rd_pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: reg_wr=%b reg_rd=%b reg_addr=%0d, required no strobe",
                             reg_wr, reg_rd, reg_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ((reg_wr && reg_rd) || reg_wr !== e.wr || reg_addr !== e.addr ||
                        (e.wr && reg_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL strobe_content: wr=%b rd=%b addr=%0d wdata=%h, required wr=%b rd=%b addr=%0d wdata=%h",
                                 reg_wr, reg_rd, reg_addr, reg_wdata, e.wr, !e.wr, e.addr, e.data);
                    end
                    pend      = 1'b1;
                    pend_rd   = !e.wr;
                    pend_data = e.data;
                end
            end
        end
    end

    task automatic start_cycle(input logic [11:0] a, input logic [2:0] c, input logic [7:0] d);
        @(negedge clk);
        addr      = a;
        cm        = c;
        data_in   = d;
        reg_rdata = d;
        adrstb_n  = 1'b0;
        if (model_hit(a, c)) exp_q.push_back('{!c[0], a[2:0], d});
        @(negedge clk);
        datstb_n = 1'b0;
    endtask

    task automatic wait_cs(input logic v, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (cs === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; adrstb_n = 1'b1; datstb_n = 1'b1;
        cm = 3'b000; addr = 12'h000; data_in = 8'h00; reg_rdata = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1)     begin errors++; $display("FAIL reset_cs: got %b, required 1", cs); end
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, required 0", data_oe); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h, required 00", data_out); end
        checks++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin errors++; $display("FAIL reset_strobes: wr=%b rd=%b, required 0 0", reg_wr, reg_rd); end
        checks++; if (reg_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h, required 00", reg_wdata); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write;
        int n; bit ok; int w0;
        w0 = wr_pulses;
        start_cycle(12'h0C3, 3'b010, 8'hA5);
        wait_cs(1'b0, 12, n, ok);
        checks++;
        if (!ok || n != SYNC + 2) begin errors++; $display("FAIL write_cs_latency: ok=%b edges=%0d, required edges=%0d", ok, n, SYNC + 2); end
        repeat (2) @(negedge clk);
        datstb_n = 1'b1; adrstb_n = 1'b1;
        wait_cs(1'b1, 12, n, ok);
        checks++;
        if (!ok || n != SYNC + 1) begin errors++; $display("FAIL write_cs_release: ok=%b edges=%0d, required edges=%0d", ok, n, SYNC + 1); end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_pulses - w0 != 1) begin errors++; $display("FAIL write_pulses: got %0d, required 1", wr_pulses - w0); end
    endtask

    task automatic test_read;
        int n; bit ok; int r0;
        r0 = rd_pulses;
        start_cycle(12'h0C6, 3'b011, 8'h3C);
        wait_cs(1'b0, 12, n, ok);
        checks++;
        if (!ok || data_oe !== 1'b1 || data_out !== 8'h3C) begin
            errors++; $display("FAIL read_data: ok=%b data_oe=%b data_out=%h, required 1 1 3c", ok, data_oe, data_out);
        end
        reg_rdata = 8'h00;
        repeat (2) @(negedge clk);
        datstb_n = 1'b1; adrstb_n = 1'b1;
        wait_cs(1'b1, 12, n, ok);
        checks++;
        if (!ok || data_oe !== 1'b0 || data_out !== 8'h3C) begin
            errors++; $display("FAIL read_release: ok=%b data_oe=%b data_out=%h, required 1 0 3c", ok, data_oe, data_out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rd_pulses - r0 != 1) begin errors++; $display("FAIL read_pulses: got %0d, required 1", rd_pulses - r0); end
    endtask

    task automatic test_nomatch;
        logic [11:0] a_tab [2];
        logic [2:0]  c_tab [2];
        a_tab[0] = 12'h0D0; c_tab[0] = 3'b011;
        a_tab[1] = 12'h0C0; c_tab[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            start_cycle(a_tab[i], c_tab[i], 8'h99);
            repeat (8) begin
                @(negedge clk);
                checks++;
                if (cs !== 1'b1 || data_oe !== 1'b0 || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
                    errors++; $display("FAIL nomatch_%0d: cs=%b oe=%b wr=%b rd=%b, required 1 0 0 0", i, cs, data_oe, reg_wr, reg_rd);
                end
            end
            datstb_n = 1'b1; adrstb_n = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_hold;
        int n; bit ok; int w0; int r0;
        start_cycle(12'h0C5, 3'b011, 8'h77);
        wait_cs(1'b0, 12, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rsthold_enter: cs=%b, required 0", cs); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cs !== 1'b1 || data_oe !== 1'b0 || data_out !== 8'h00 || reg_wr !== 1'b0 ||
            reg_rd !== 1'b0 || reg_addr !== 3'd0 || reg_wdata !== 8'h00) begin
            errors++; $display("FAIL rsthold_values: cs=%b oe=%b dout=%h wr=%b rd=%b addr=%0d wdata=%h, required 1 0 00 0 0 0 00",
                               cs, data_oe, data_out, reg_wr, reg_rd, reg_addr, reg_wdata);
        end
        rst = 1'b0;
        w0 = wr_pulses; r0 = rd_pulses;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (cs !== 1'b1 || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
                errors++; $display("FAIL rsthold_quiet: cs=%b wr=%b rd=%b, required 1 0 0", cs, reg_wr, reg_rd);
            end
        end
        datstb_n = 1'b1; adrstb_n = 1'b1;
        repeat (3) @(negedge clk);
        start_cycle(12'h0C1, 3'b010, 8'h5A);
        wait_cs(1'b0, 12, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rsthold_next_cs: cs=%b, required 0", cs); end
        @(negedge clk);
        datstb_n = 1'b1; adrstb_n = 1'b1;
        wait_cs(1'b1, 12, n, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || wr_pulses - w0 != 1 || rd_pulses - r0 != 0) begin
            errors++; $display("FAIL rsthold_next: ok=%b wr=%0d rd=%0d, required 1 1 0", ok, wr_pulses - w0, rd_pulses - r0);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] a_tab [4];
        logic [7:0]  d_tab [4];
        int w0;
        a_tab[0] = 12'h0C4; d_tab[0] = 8'h11;
        a_tab[1] = 12'h0C7; d_tab[1] = 8'h22;
        a_tab[2] = 12'h0C2; d_tab[2] = 8'h33;
        a_tab[3] = 12'h0C0; d_tab[3] = 8'h44;
        w0 = wr_pulses;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = a_tab[i]; cm = 3'b010; data_in = d_tab[i];
            adrstb_n = 1'b0; datstb_n = 1'b0;
            if (model_hit(a_tab[i], 3'b010)) exp_q.push_back('{1'b1, a_tab[i][2:0], d_tab[i]});
            repeat (4) @(negedge clk);
            datstb_n = 1'b1; adrstb_n = 1'b1;
        end
        repeat (8) @(negedge clk);
        checks++;
        if (wr_pulses - w0 != 4 || exp_q.size() != 0 || cs !== 1'b1) begin
            errors++; $display("FAIL b2b: pulses=%0d pending=%0d cs=%b, required 4 0 1", wr_pulses - w0, exp_q.size(), cs);
        end
    endtask

    task automatic test_short;
        int  r0; int w0; bit low_seen;
        r0 = rd_pulses; low_seen = 1'b0;
        start_cycle(12'h0C2, 3'b011, 8'hC3);
        repeat (SYNC + 1) begin
            @(negedge clk);
            if (cs === 1'b0) low_seen = 1'b1;
        end
        datstb_n = 1'b1; adrstb_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (cs === 1'b0) low_seen = 1'b1;
        end
        checks++;
        if (rd_pulses - r0 != 1 || !low_seen || cs !== 1'b1 || data_oe !== 1'b0) begin
            errors++; $display("FAIL short_read: pulses=%0d cs_low=%b cs=%b oe=%b, required 1 1 1 0", rd_pulses - r0, low_seen, cs, data_oe);
        end
        // DATSTB* low for a single clock: the synchronised rise lands while in STROBE.
        w0 = wr_pulses; low_seen = 1'b0;
        start_cycle(12'h0C7, 3'b010, 8'hE1);
        @(negedge clk);
        datstb_n = 1'b1; adrstb_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (cs === 1'b0) low_seen = 1'b1;
        end
        checks++;
        if (wr_pulses - w0 != 1 || !low_seen || cs !== 1'b1) begin
            errors++; $display("FAIL strobe_rise: pulses=%0d cs_low=%b cs=%b, required 1 1 1", wr_pulses - w0, low_seen, cs);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_nomatch;
        test_reset_hold;
        test_back_to_back;
        test_short;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
